ldpc_min2_finder: RTL and testbench

//  Pipelined min-sum check-node magnitude reducer for the LDPC decoder.
//  - Finds min1 (smallest), min2 (second smallest) and the min1 location across NUM_INPUTS unsigned lanes per beat.
//  - Folds up to MAX_BEATS beats of one check row into a single result, so row degrees larger than NUM_INPUTS are supported.
//  - Sits between the variable-to-check magnitude extraction and the check-to-variable update stage.

---
 rtl/ldpc_min2_finder.sv | 200 ++++++++++++++++++++
 tb/tb_ldpc_min2_finder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_min2_finder.sv
// rtl/ldpc_min2_finder.sv - pipelined min1/min2/index reducer with multi-beat row folding
module ldpc_min2_finder #(
  parameter  int WIDTH      = 8,
  parameter  int NUM_INPUTS = 8,
  parameter  int MAX_BEATS  = 4,
  localparam int IDX_W      = $clog2(NUM_INPUTS * MAX_BEATS)
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic [NUM_INPUTS*WIDTH-1:0]   i_in_data,
  input  logic [NUM_INPUTS-1:0]         i_in_mask,
  input  logic                          i_in_valid,
  input  logic                          i_in_first,
  input  logic                          i_in_last,
  output logic [WIDTH-1:0]              o_min1,
  output logic [WIDTH-1:0]              o_min2,
  output logic [IDX_W-1:0]              o_min1_index,
  output logic                          o_out_valid,
  output logic                          o_error
);

  localparam int LEVELS = $clog2(NUM_INPUTS);
  localparam int NODES  = NUM_INPUTS - 1;
  localparam int CNT_W  = $clog2(MAX_BEATS + 1);

  typedef struct packed {
    logic [WIDTH-1:0] m1;
    logic [WIDTH-1:0] m2;
    logic [IDX_W-1:0] idx;
  } node_t;

  typedef enum logic {IDLE, ACCUM} state_t;

  // a is always the lower-index side, so ties keep a's location
  function automatic node_t merge(input node_t a, input node_t b);
    node_t r;
    if (a.m1 <= b.m1) begin
      r.m1  = a.m1;
      r.idx = a.idx;
      r.m2  = (a.m2 < b.m1) ? a.m2 : b.m1;
    end else begin
      r.m1  = b.m1;
      r.idx = b.idx;
      r.m2  = (b.m2 < a.m1) ? b.m2 : a.m1;
    end
    return r;
  endfunction

  // Tree is laid out as a heap: entries 0..NODES-1 are registered merge
  // nodes, entries NODES..2*NUM_INPUTS-2 are the combinational leaves.
  // Every leaf sits at the same depth, so each heap level is one stage.
  node_t all_n [2*NUM_INPUTS-1];
  node_t nd_d  [NODES];
  node_t nd_q  [NODES];

  logic [LEVELS-1:0] vld_q;
  logic [LEVELS-1:0] fst_q;
  logic [LEVELS-1:0] lst_q;

  // Build the flat heap view: registered nodes plus masked leaves
  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      all_n[i] = nd_q[i];
    end
    for (int k = 0; k < NUM_INPUTS; k++) begin
      all_n[NODES+k].m1  = i_in_mask[k] ? i_in_data[k*WIDTH +: WIDTH] : '1;
      all_n[NODES+k].m2  = '1;
      all_n[NODES+k].idx = IDX_W'(k);
    end
  end

  // One merge per node from its two children; left child holds lower lanes
  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      nd_d[i] = merge(all_n[2*i+1], all_n[2*i+2]);
    end
  end

  // Register every tree node each cycle; no backpressure, no enable needed
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NODES; i++) begin
        nd_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NODES; i++) begin
        nd_q[i] <= nd_d[i];
      end
    end
  end

  // Carry the beat flags alongside the tree so they emerge with the root
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q[0] <= i_in_valid;
      fst_q[0] <= i_in_valid & i_in_first;
      lst_q[0] <= i_in_valid & i_in_last;
      for (int s = 1; s < LEVELS; s++) begin
        vld_q[s] <= vld_q[s-1];
        fst_q[s] <= fst_q[s-1];
        lst_q[s] <= lst_q[s-1];
      end
    end
  end

  logic  t_valid;
  logic  t_first;
  logic  t_last;
  node_t root;
  node_t root_off;
  node_t merged;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  node_t            acc_q;
  logic [WIDTH-1:0] min1_q;
  logic [WIDTH-1:0] min2_q;
  logic [IDX_W-1:0] idx_q;
  logic             out_valid_q;
  logic             error_q;

  assign t_valid = vld_q[LEVELS-1];
  assign t_first = fst_q[LEVELS-1];
  assign t_last  = lst_q[LEVELS-1];
  assign root    = nd_q[0];

  // Rebase the incoming beat's lane index to its position within the row
  always_comb begin
    root_off     = root;
    root_off.idx = root.idx + IDX_W'(cnt_q) * IDX_W'(NUM_INPUTS);
    merged       = merge(acc_q, root_off);
  end

  // Row accumulator: folds tree results beat by beat and emits on last
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      min1_q      <= '0;
      min2_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
      if (t_valid) begin
        if (t_first) begin
          // A first arriving mid-group abandons the partial row
          error_q <= (state_q == ACCUM);
          acc_q   <= root;
          cnt_q   <= CNT_W'(1);
          if (t_last) begin
            min1_q      <= root.m1;
            min2_q      <= root.m2;
            idx_q       <= root.idx;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= ACCUM;
          end
        end else if (state_q == IDLE) begin
          error_q <= 1'b1;
        end else if (cnt_q == CNT_W'(MAX_BEATS)) begin
          // Overlong row: beat does not contribute, but last still closes it
          error_q <= 1'b1;
          if (t_last) begin
            min1_q      <= acc_q.m1;
            min2_q      <= acc_q.m2;
            idx_q       <= acc_q.idx;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end else begin
          acc_q <= merged;
          cnt_q <= cnt_q + CNT_W'(1);
          if (t_last) begin
            min1_q      <= merged.m1;
            min2_q      <= merged.m2;
            idx_q       <= merged.idx;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
      end
    end
  end

  assign o_min1       = min1_q;
  assign o_min2       = min2_q;
  assign o_min1_index = idx_q;
  assign o_out_valid  = out_valid_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_ldpc_min2_finder.sv
// tb/tb_ldpc_min2_finder.sv - directed and random checks for ldpc_min2_finder
module tb_ldpc_min2_finder;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int MB = 4;
  localparam int IW = 5;

  logic            clk;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_mask;
  logic            in_valid;
  logic            in_first;
  logic            in_last;
  logic [W-1:0]    min1;
  logic [W-1:0]    min2;
  logic [IW-1:0]   min1_index;
  logic            out_valid;
  logic            error;

  int checks;
  int errors;
  int cyc;
  int bcyc;
  int vcnt;
  int ecnt;
  int cap_m1  [8];
  int cap_m2  [8];
  int cap_idx [8];
  int cap_cyc [8];
  int vals    [32];

  ldpc_min2_finder #(.WIDTH(W), .NUM_INPUTS(N), .MAX_BEATS(MB)) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_in_data    (in_data),
    .i_in_mask    (in_mask),
    .i_in_valid   (in_valid),
    .i_in_first   (in_first),
    .i_in_last    (in_last),
    .o_min1       (min1),
    .o_min2       (min2),
    .o_min1_index (min1_index),
    .o_out_valid  (out_valid),
    .o_error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      if (vcnt < 8) begin
        cap_m1[vcnt]  = int'(min1);
        cap_m2[vcnt]  = int'(min2);
        cap_idx[vcnt] = int'(min1_index);
        cap_cyc[vcnt] = cyc;
      end
      vcnt = vcnt + 1;
    end
    if (error) ecnt = ecnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] lanes(input int v0, input int v1, input int v2, input int v3,
                                           input int v4, input int v5, input int v6, input int v7);
    logic [N*W-1:0] r;
    r = {v7[7:0], v6[7:0], v5[7:0], v4[7:0], v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
    return r;
  endfunction

  task automatic beat(input logic [N*W-1:0] d, input logic [N-1:0] m, input logic f, input logic l);
    in_data  = d;
    in_mask  = m;
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    bcyc     = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    vcnt = 0;
    ecnt = 0;
  endtask

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   m;
    int nb, e1, e2, ei, v;

    checks = 0; errors = 0; cyc = 0; vcnt = 0; ecnt = 0; bcyc = 0;
    rst_n = 1'b0; in_data = '0; in_mask = '0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    #2;
    check("reset_min1", int'(min1), 0);
    check("reset_min2", int'(min2), 0);
    check("reset_idx", int'(min1_index), 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_error", int'(error), 0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single beat, latency
    clr();
    beat(lanes(9, 4, 7, 4, 12, 30, 2, 5), 8'hFF, 1'b1, 1'b1);
    idle(8);
    check("t1_vcnt", vcnt, 1);
    check("t1_min1", cap_m1[0], 2);
    check("t1_min2", cap_m2[0], 4);
    check("t1_idx", cap_idx[0], 6);
    check("t1_latency", cap_cyc[0] - bcyc, 4);
    check("t1_err", ecnt, 0);

    // Ties
    clr();
    beat(lanes(3, 3, 8, 8, 8, 8, 8, 8), 8'hFF, 1'b1, 1'b1);
    idle(8);
    check("t2_min1", cap_m1[0], 3);
    check("t2_min2", cap_m2[0], 3);
    check("t2_idx", cap_idx[0], 0);

    // Two-beat group
    clr();
    beat(lanes(10, 20, 50, 50, 50, 50, 50, 50), 8'hFF, 1'b1, 1'b0);
    beat(lanes(15, 1, 50, 50, 50, 50, 50, 50), 8'hFF, 1'b0, 1'b1);
    idle(8);
    check("t3_vcnt", vcnt, 1);
    check("t3_min1", cap_m1[0], 1);
    check("t3_min2", cap_m2[0], 10);
    check("t3_idx", cap_idx[0], 9);

    // Masking
    clr();
    beat(lanes(200, 0, 0, 0, 0, 0, 0, 0), 8'h01, 1'b1, 1'b1);
    beat(lanes(1, 2, 3, 4, 5, 6, 7, 8), 8'h00, 1'b1, 1'b1);
    idle(8);
    check("t4_vcnt", vcnt, 2);
    check("t4_min1", cap_m1[0], 200);
    check("t4_min2", cap_m2[0], 255);
    check("t4_idx", cap_idx[0], 0);
    check("t4_all_min1", cap_m1[1], 255);
    check("t4_all_min2", cap_m2[1], 255);
    check("t4_all_idx", cap_idx[1], 0);
    check("t4_b2b_gap", cap_cyc[1] - cap_cyc[0], 1);

    // Beat without first in IDLE
    clr();
    beat(lanes(1, 1, 1, 1, 1, 1, 1, 1), 8'hFF, 1'b0, 1'b1);
    idle(8);
    check("t5a_err", ecnt, 1);
    check("t5a_vcnt", vcnt, 0);

    // First mid-group
    clr();
    beat(lanes(1, 1, 1, 1, 1, 1, 1, 1), 8'hFF, 1'b1, 1'b0);
    beat(lanes(20, 21, 22, 23, 24, 25, 26, 6), 8'hFF, 1'b1, 1'b1);
    idle(8);
    check("t5b_err", ecnt, 1);
    check("t5b_vcnt", vcnt, 1);
    check("t5b_min1", cap_m1[0], 6);
    check("t5b_min2", cap_m2[0], 20);
    check("t5b_idx", cap_idx[0], 7);

    // Overlong group: fifth beat ignored
    clr();
    for (int b = 0; b < 4; b++) begin
      beat(lanes(100, 100, 50 - 5 * b, 100, 100, 100, 100, 100), 8'hFF, b == 0, 1'b0);
    end
    beat(lanes(1, 100, 100, 100, 100, 100, 100, 100), 8'hFF, 1'b0, 1'b1);
    idle(8);
    check("t5c_err", ecnt, 1);
    check("t5c_vcnt", vcnt, 1);
    check("t5c_min1", cap_m1[0], 35);
    check("t5c_min2", cap_m2[0], 40);
    check("t5c_idx", cap_idx[0], 26);

    // Reset mid-group
    clr();
    beat(lanes(1, 1, 1, 1, 1, 1, 1, 1), 8'hFF, 1'b1, 1'b0);
    idle(1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_min1", int'(min1), 0);
    check("t6_rst_min2", int'(min2), 0);
    check("t6_rst_idx", int'(min1_index), 0);
    idle(2);
    rst_n = 1'b1;
    idle(8);
    check("t6_no_emit", vcnt, 0);
    check("t6_no_err", ecnt, 0);
    clr();
    beat(lanes(9, 4, 7, 4, 12, 30, 2, 5), 8'hFF, 1'b1, 1'b1);
    idle(8);
    check("t6_vcnt", vcnt, 1);
    check("t6_min1", cap_m1[0], 2);
    check("t6_min2", cap_m2[0], 4);
    check("t6_idx", cap_idx[0], 6);

    // Random groups against a sort-style reference
    for (int g = 0; g < 12; g++) begin
      clr();
      nb = $urandom_range(1, MB);
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < N; k++) begin
          v = (g % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
          d[k*W +: W] = v[7:0];
        end
        m = $urandom_range(0, 255);
        if (g < 4) m = 8'hFF;
        for (int k = 0; k < N; k++) vals[b*N + k] = m[k] ? int'(d[k*W +: W]) : 255;
        beat(d, m, b == 0, b == nb - 1);
      end
      idle(8);
      e1 = 255; ei = 0;
      for (int j = 0; j < nb * N; j++) begin
        if (vals[j] < e1) begin
          e1 = vals[j];
          ei = j;
        end
      end
      e2 = 255;
      for (int j = 0; j < nb * N; j++) begin
        if (j != ei && vals[j] < e2) e2 = vals[j];
      end
      check("rnd_vcnt", vcnt, 1);
      check("rnd_min1", cap_m1[0], e1);
      check("rnd_min2", cap_m2[0], e2);
      check("rnd_idx", cap_idx[0], ei);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
